// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the CPU-side RAM access controller.
// Holds the default RAM geometry and the access FSM state encoding.
package mem_access_ctrl_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// Single RAM master for byte and 16-bit little-endian word accesses.
// Runs one or two RAM cycles per request and assembles the read result.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BYTE_W = DEF_BYTE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                wr,
  input  logic                word,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [2*BYTE_W-1:0] wdata,
  output logic                ready,
  output logic                done,
  output logic [2*BYTE_W-1:0] rdata,
  output logic                mem_ce,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [BYTE_W-1:0]   mem_wdata,
  input  logic [BYTE_W-1:0]   mem_rdata
);

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic                  word_q, word_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [2*BYTE_W-1:0]   wdata_q, wdata_d;
  logic [2*BYTE_W-1:0]   rdata_q, rdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      word_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM strobes depend only on state and latched operands, so live CPU inputs
  // can toggle freely while an access is in flight.
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    word_d    = word_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ready     = 1'b0;
    done      = 1'b0;
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          wr_d    = wr;
          word_d  = word;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = ACC_LO;
        end
      end
      ACC_LO: begin
        mem_ce    = 1'b1;
        mem_we    = wr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q[BYTE_W-1:0];
        if (!wr_q) begin
          rdata_d[BYTE_W-1:0] = mem_rdata;
          if (!word_q) rdata_d[2*BYTE_W-1:BYTE_W] = '0;
        end
        state_d = word_q ? ACC_HI : DONE;
      end
      ACC_HI: begin
        mem_ce    = 1'b1;
        mem_we    = wr_q;
        mem_addr  = addr_q + ADDR_W'(1);
        mem_wdata = wdata_q[2*BYTE_W-1:BYTE_W];
        if (!wr_q) rdata_d[2*BYTE_W-1:BYTE_W] = mem_rdata;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with a 64K x 8 RAM model and an
// operation-level reference model (byte array plus last-read register).
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic        word = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        ready;
  logic        done;
  logic [15:0] rdata;
  logic        mem_ce;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram    [0:65535];
  logic [7:0]  refMem [0:65535];
  logic [15:0] lastRead;

  int total = 0;
  int bad = 0;

  mem_access_ctrl #(.ADDR_W(16), .BYTE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .word(word),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM: synchronous write, combinational read while enabled
  always @(posedge clk) if (mem_ce && mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_ce ? ram[mem_addr] : 8'h00;

  typedef struct {
    logic        w;
    logic        wd;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] expR;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour of one request at the transaction level
  task automatic modelOp(input logic w, input logic wd, input logic [15:0] a,
                         input logic [15:0] d, output logic [15:0] expR);
    logic [15:0] a1;
    a1 = a + 16'd1;
    if (w) begin
      refMem[a] = d[7:0];
      if (wd) refMem[a1] = d[15:8];
    end else begin
      lastRead = wd ? {refMem[a1], refMem[a]} : {8'h00, refMem[a]};
    end
    expR = lastRead;
  endtask

  // Issue one request from IDLE and follow it to its done pulse
  task automatic runOp(input logic w, input logic wd, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] expR);
    int lat;
    int ce;
    int g;
    logic [15:0] addrs[$];
    logic [15:0] a1;
    a1 = a + 16'd1;
    g = 0;
    while (!ready && g < 10) begin
      @(posedge clk); #1; g++;
    end
    check("ready_before_req", ready, 1'b1);
    req = 1'b1; wr = w; word = wd; addr = a; wdata = d;
    @(posedge clk); #1;
    req = $urandom_range(0, 1); wr = $urandom_range(0, 1); word = $urandom_range(0, 1);
    addr = $urandom; wdata = $urandom;
    lat = 1; ce = 0;
    while (!done && lat < 10) begin
      check("ready_low_busy", ready, 1'b0);
      if (mem_ce) begin
        check("mem_we", mem_we, w);
        if (w) check("mem_wdata", mem_wdata, (ce == 0) ? d[7:0] : d[15:8]);
        addrs.push_back(mem_addr);
        ce++;
      end
      @(posedge clk); #1; lat++;
    end
    req = 1'b0;
    check("done_seen", done, 1'b1);
    check("latency", lat, wd ? 3 : 2);
    check("ce_cycles", ce, wd ? 2 : 1);
    check("mem_ce_in_done", mem_ce, 1'b0);
    if (addrs.size() > 0) check("addr_lo", addrs[0], a);
    if (wd && addrs.size() > 1) check("addr_hi", addrs[1], a1);
    check("rdata", rdata, expR);
    @(posedge clk); #1;
    check("done_one_cycle", done, 1'b0);
    if (w) begin
      check("ram_lo", ram[a], refMem[a]);
      if (wd) check("ram_hi", ram[a1], refMem[a1]);
    end
  endtask

  initial begin
    logic [15:0] expR;
    logic [15:0] ra;
    logic [15:0] rd;
    logic        rw;
    logic        rwd;
    logic [7:0]  oldHi;

    for (int i = 0; i < 65536; i++) begin
      ram[i]    = 8'($urandom);
      refMem[i] = ram[i];
    end
    lastRead = 16'h0000;

    vecs[0] = '{1'b1, 1'b0, 16'h0100, 16'h005A, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 16'h005A};
    vecs[2] = '{1'b1, 1'b1, 16'h2000, 16'hBEEF, 16'h005A};
    vecs[3] = '{1'b0, 1'b1, 16'h2000, 16'h0000, 16'hBEEF};
    vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 16'h0034, 16'hBEEF};
    vecs[5] = '{1'b1, 1'b0, 16'h0000, 16'hAB12, 16'hBEEF};
    vecs[6] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h1234};
    vecs[7] = '{1'b0, 1'b0, 16'h2001, 16'h0000, 16'h00BE};
    vecs[8] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0012};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_ce", mem_ce, 1'b0);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_mem_addr", mem_addr, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      modelOp(vecs[i].w, vecs[i].wd, vecs[i].a, vecs[i].d, expR);
      runOp(vecs[i].w, vecs[i].wd, vecs[i].a, vecs[i].d, vecs[i].expR);
    end
    check("ram_2000", ram[16'h2000], 8'hEF);
    check("ram_2001", ram[16'h2001], 8'hBE);

    for (int n = 0; n < 150; n++) begin
      rw  = 1'($urandom_range(0, 1));
      rwd = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15))
                                        : 16'hFFF0 + 16'($urandom_range(0, 15));
      rd  = 16'($urandom);
      modelOp(rw, rwd, ra, rd, expR);
      runOp(rw, rwd, ra, rd, expR);
    end

    // Back-to-back byte reads with req held high
    req = 1'b1; wr = 1'b0; word = 1'b0; addr = 16'h0100;
    for (int k = 0; k < 12; k++) begin
      check("stream_done", done, (k % 3) == 2);
      check("stream_ready", ready, (k % 3) == 0);
      @(posedge clk); #1;
    end
    req = 1'b0;
    lastRead = {8'h00, refMem[16'h0100]};
    check("stream_rdata", rdata, lastRead);

    // Reset while the high byte of a word write is on the bus
    oldHi = refMem[16'h0201];
    req = 1'b1; wr = 1'b1; word = 1'b1; addr = 16'h0200; wdata = 16'hC3A5;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    check("hi_ce", mem_ce, 1'b1);
    check("hi_addr", mem_addr, 16'h0201);
    rst_n = 1'b0;
    #1;
    check("midrst_ce", mem_ce, 1'b0);
    check("midrst_ready", ready, 1'b1);
    check("midrst_done", done, 1'b0);
    check("midrst_rdata", rdata, 16'h0000);
    @(posedge clk); #1;
    check("midrst_ram_lo", ram[16'h0200], 8'hA5);
    check("midrst_ram_hi", ram[16'h0201], oldHi);
    refMem[16'h0200] = 8'hA5;
    lastRead = 16'h0000;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    runOp(1'b0, 1'b1, 16'h0200, 16'h0000, {oldHi, 8'hA5});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
